// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 fetch shared types, icode constants and length helper
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;
    localparam int         MAX_LEN = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DONE
    } fetch_state_t;

    // Unknown icodes are treated as one-byte instructions.
    function automatic logic [3:0] inst_len(input logic [3:0] icode);
        case (icode)
            ICODE_HALT, ICODE_NOP, ICODE_RET:                  return 4'd1;
            ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ:  return 4'd2;
            ICODE_JXX, ICODE_CALL:                             return 4'd9;
            ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:          return 4'd10;
            default:                                           return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/y86_ilen_decode.sv
// rtl/y86_ilen_decode.sv - icode to instruction length and field layout
module y86_ilen_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       has_regs,
    output logic       has_valc,
    output logic [3:0] valc_off,
    output logic       invalid
);

    always_comb begin
        len      = inst_len(icode);
        invalid  = (icode > ICODE_POPQ);
        has_regs = (len == 4'd2) || (len == 4'd10);
        has_valc = (len == 4'd9) || (len == 4'd10);
        valc_off = (len == 4'd10) ? 4'd2 : 4'd1;
    end

endmodule

// File: rtl/y86_fetch_sequencer.sv
// rtl/y86_fetch_sequencer.sv - multi-cycle byte-wide Y86-64 instruction fetch and field decode
module y86_fetch_sequencer
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [ADDR_W-1:0] valP,
    output logic              imem_error,
    output logic              instr_invalid
);

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [3:0]        idx_q;
    logic [7:0]        byte_q [MAX_LEN];

    logic              accept;
    logic              pc_in_range;
    logic [3:0]        idx_next;
    logic [ADDR_W-1:0] next_addr;
    logic              next_in_range;
    logic              more_bytes;
    logic              enter_done;
    logic              fetch_err;

    logic [3:0]        dec_icode;
    logic [3:0]        dec_len;
    logic              dec_has_regs;
    logic              dec_has_valc;
    logic [3:0]        dec_valc_off;
    logic              dec_invalid;

    logic [7:0]        cur_byte [MAX_LEN];
    logic [63:0]       cur_valc;
    logic [3:0]        cur_ra;
    logic [3:0]        cur_rb;

    assign pc_ready      = (state_q == ST_IDLE) && !rst;
    assign accept        = pc_valid && pc_ready && !flush;
    assign inst_valid    = (state_q == ST_DONE);
    assign pc_in_range   = (pc_in < MEM_LIMIT);

    // Byte 0 is decoded straight off the ROM bus in the cycle it arrives.
    assign dec_icode     = (idx_q == 4'd0) ? mem_rdata[7:4] : byte_q[0][7:4];
    assign idx_next      = idx_q + 4'd1;
    assign next_addr     = pc_q + ADDR_W'(idx_next);
    assign next_in_range = (next_addr < MEM_LIMIT);
    assign more_bytes    = (idx_next < dec_len);

    y86_ilen_decode u_ilen_decode (
        .icode    (dec_icode),
        .len      (dec_len),
        .has_regs (dec_has_regs),
        .has_valc (dec_has_valc),
        .valc_off (dec_valc_off),
        .invalid  (dec_invalid)
    );

    always_comb begin
        state_d    = state_q;
        mem_ren    = 1'b0;
        mem_addr   = '0;
        enter_done = 1'b0;
        fetch_err  = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (pc_in_range) begin
                            mem_ren  = 1'b1;
                            mem_addr = pc_in;
                            state_d  = ST_FETCH;
                        end else begin
                            state_d  = ST_DONE;
                        end
                    end
                end
                ST_FETCH: begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else if (more_bytes) begin
                        if (next_in_range) begin
                            mem_ren  = 1'b1;
                            mem_addr = next_addr;
                        end else begin
                            fetch_err  = 1'b1;
                            enter_done = 1'b1;
                            state_d    = ST_DONE;
                        end
                    end else begin
                        enter_done = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (flush || inst_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Buffer view including the byte on the bus this cycle; unfetched bytes stay zero.
    always_comb begin
        logic [3:0] sel;
        sel = 4'd0;
        for (int i = 0; i < MAX_LEN; i++) begin
            cur_byte[i] = byte_q[i];
        end
        if (idx_q < 4'(MAX_LEN)) begin
            cur_byte[idx_q] = mem_rdata;
        end
        cur_ra = dec_has_regs ? cur_byte[1][7:4] : RNONE;
        cur_rb = dec_has_regs ? cur_byte[1][3:0] : RNONE;
        cur_valc = '0;
        for (int i = 0; i < 8; i++) begin
            sel = dec_valc_off + 4'(i);
            cur_valc[8*i +: 8] = dec_has_valc ? cur_byte[sel] : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            idx_q         <= 4'd0;
            for (int i = 0; i < MAX_LEN; i++) begin
                byte_q[i] <= 8'h00;
            end
            icode         <= 4'h0;
            ifun          <= 4'h0;
            rA            <= RNONE;
            rB            <= RNONE;
            valC          <= '0;
            valP          <= '0;
            imem_error    <= 1'b0;
            instr_invalid <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        pc_q          <= pc_in;
                        idx_q         <= 4'd0;
                        for (int i = 0; i < MAX_LEN; i++) begin
                            byte_q[i] <= 8'h00;
                        end
                        instr_invalid <= 1'b0;
                        imem_error    <= !pc_in_range;
                        if (!pc_in_range) begin
                            icode <= ICODE_NOP;
                            ifun  <= 4'h0;
                            rA    <= RNONE;
                            rB    <= RNONE;
                            valC  <= '0;
                            valP  <= pc_in;
                        end
                    end
                end
                ST_FETCH: begin
                    if (!flush) begin
                        if (idx_q < 4'(MAX_LEN)) begin
                            byte_q[idx_q] <= mem_rdata;
                        end
                        if (mem_ren) begin
                            idx_q <= idx_next;
                        end
                        if (enter_done) begin
                            icode         <= cur_byte[0][7:4];
                            ifun          <= cur_byte[0][3:0];
                            rA            <= cur_ra;
                            rB            <= cur_rb;
                            valC          <= cur_valc;
                            valP          <= pc_q + ADDR_W'(dec_len);
                            imem_error    <= fetch_err;
                            instr_invalid <= dec_invalid;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_fetch_sequencer.sv
// tb/tb_y86_fetch_sequencer.sv - directed-vector bench for y86_fetch_sequencer
module tb_y86_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic [63:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        mem_ren;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        imem_error;
    logic        instr_invalid;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  rom [1024];
    logic [63:0] ren_log [64];
    int          ren_total = 0;

    y86_fetch_sequencer #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_in         (pc_in),
        .pc_valid      (pc_valid),
        .pc_ready      (pc_ready),
        .flush         (flush),
        .mem_ren       (mem_ren),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .icode         (icode),
        .ifun          (ifun),
        .rA            (rA),
        .rB            (rB),
        .valC          (valC),
        .valP          (valP),
        .imem_error    (imem_error),
        .instr_invalid (instr_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= (mem_addr < 64'd1024) ? rom[mem_addr[9:0]] : 8'h00;
        if (mem_ren) begin
            ren_log[ren_total % 64] <= mem_addr;
            ren_total <= ren_total + 1;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_fetch(input string tag, input logic [63:0] pc, input int e_lat, input int e_reads,
                             input logic [3:0] e_icode, input logic [3:0] e_ifun,
                             input logic [3:0] e_ra, input logic [3:0] e_rb,
                             input logic [63:0] e_valc, input logic [63:0] e_valp,
                             input logic e_err, input logic e_inv, input int hold);
        int lat;
        int start;
        start = ren_total;
        pc_in = pc;
        pc_valid = 1'b1;
        check_val({tag, ".pc_ready"}, 64'(pc_ready), 64'd1);
        @(negedge clk);
        pc_valid = 1'b0;
        pc_in = '0;
        lat = 1;
        while (!inst_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, ".latency"}, 64'(lat), 64'(e_lat));
        check_val({tag, ".icode"}, 64'(icode), 64'(e_icode));
        check_val({tag, ".ifun"}, 64'(ifun), 64'(e_ifun));
        check_val({tag, ".rA"}, 64'(rA), 64'(e_ra));
        check_val({tag, ".rB"}, 64'(rB), 64'(e_rb));
        check_val({tag, ".valC"}, valC, e_valc);
        check_val({tag, ".valP"}, valP, e_valp);
        check_val({tag, ".imem_error"}, 64'(imem_error), 64'(e_err));
        check_val({tag, ".instr_invalid"}, 64'(instr_invalid), 64'(e_inv));
        check_val({tag, ".reads"}, 64'(ren_total - start), 64'(e_reads));
        for (int i = 0; i < e_reads && i < 16; i++) begin
            check_val({tag, ".addr"}, ren_log[(start + i) % 64], pc + 64'(i));
        end
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            check_val({tag, ".hold_valid"}, 64'(inst_valid), 64'd1);
            check_val({tag, ".hold_icode"}, 64'(icode), 64'(e_icode));
            check_val({tag, ".hold_rB"}, 64'(rB), 64'(e_rb));
            check_val({tag, ".hold_valC"}, valC, e_valc);
            check_val({tag, ".hold_valP"}, valP, e_valp);
            check_val({tag, ".hold_reads"}, 64'(ren_total - start), 64'(e_reads));
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        check_val({tag, ".released"}, 64'(inst_valid), 64'd0);
        check_val({tag, ".pc_ready_after"}, 64'(pc_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
        rom[0] = 8'h30; rom[1] = 8'hF2; rom[2] = 8'h0A;
        rom[32'h020] = 8'h00;
        rom[32'h030] = 8'h70; rom[32'h032] = 8'h01;
        rom[32'h040] = 8'hC0;
        rom[32'h050] = 8'h61; rom[32'h051] = 8'h23;
        rom[32'h3FE] = 8'h30; rom[32'h3FF] = 8'h45;

        rst = 1'b1; pc_in = '0; pc_valid = 1'b0; flush = 1'b0; inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_val("reset.pc_ready", 64'(pc_ready), 64'd0);
        check_val("reset.inst_valid", 64'(inst_valid), 64'd0);
        check_val("reset.mem_ren", 64'(mem_ren), 64'd0);
        check_val("reset.rA", 64'(rA), 64'hF);
        check_val("reset.valP", valP, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("reset.pc_ready_released", 64'(pc_ready), 64'd1);

        run_fetch("irmovq", 64'h0,   11, 10, 4'h3, 4'h0, 4'hF, 4'h2, 64'hA,   64'hA,   1'b0, 1'b0, 5);
        run_fetch("halt",   64'h20,   2,  1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,   64'h21,  1'b0, 1'b0, 0);
        run_fetch("jmp",    64'h30,  10,  9, 4'h7, 4'h0, 4'hF, 4'hF, 64'h100, 64'h39,  1'b0, 1'b0, 0);
        run_fetch("subq",   64'h50,   3,  2, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0,   64'h52,  1'b0, 1'b0, 0);
        run_fetch("edge",   64'h3FE,  3,  2, 4'h3, 4'h0, 4'h4, 4'h5, 64'h0,   64'h408, 1'b1, 1'b0, 0);
        run_fetch("oob",    64'h500,  1,  0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,   64'h500, 1'b1, 1'b0, 0);
        run_fetch("bad",    64'h40,   2,  1, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0,   64'h41,  1'b0, 1'b1, 0);

        pc_in = 64'h0; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_val("flush.pc_ready", 64'(pc_ready), 64'd1);
        check_val("flush.inst_valid", 64'(inst_valid), 64'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (inst_valid) seen = 1;
        end
        check_val("flush.no_handoff", 64'(seen), 64'd0);
        run_fetch("after_flush", 64'h20, 2, 1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h21, 1'b0, 1'b0, 0);

        pc_in = 64'h0; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_mid.pc_ready", 64'(pc_ready), 64'd0);
        check_val("rst_mid.inst_valid", 64'(inst_valid), 64'd0);
        check_val("rst_mid.mem_ren", 64'(mem_ren), 64'd0);
        check_val("rst_mid.mem_addr", mem_addr, 64'd0);
        check_val("rst_mid.icode", 64'(icode), 64'd0);
        check_val("rst_mid.rA", 64'(rA), 64'hF);
        check_val("rst_mid.rB", 64'(rB), 64'hF);
        check_val("rst_mid.valC", valC, 64'd0);
        check_val("rst_mid.valP", valP, 64'd0);
        check_val("rst_mid.imem_error", 64'(imem_error), 64'd0);
        check_val("rst_mid.instr_invalid", 64'(instr_invalid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_mid.pc_ready_released", 64'(pc_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
